axil_image_loader: RTL and testbench

AXIL_IMAGE_LOADER -- requirements
Module: axil_image_loader

---
 rtl/axil_image_loader.sv | 205 ++++++++++++++++++++
 tb/tb_axil_image_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_image_loader.sv
// AXI4-Lite slave that loads an image into a flat pixel register, starts the SNN and captures its result.
// Define SNN_AXIL_READBACK_EN to let pixel-word reads return stored pixels; otherwise they return 0.
module axil_image_loader #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int IMAGE_SIZE     = 256,
  parameter int PIXEL_BITS     = 8,
  parameter int M              = 8
) (
  input  logic                             ACLK,
  input  logic                             ARESETN,
  input  logic [AXI_ADDR_WIDTH-1:0]        AWADDR,
  input  logic                             AWVALID,
  output logic                             AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]        WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]      WSTRB,
  input  logic                             WVALID,
  output logic                             WREADY,
  output logic [1:0]                       BRESP,
  output logic                             BVALID,
  input  logic                             BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]        ARADDR,
  input  logic                             ARVALID,
  output logic                             ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]        RDATA,
  output logic [1:0]                       RRESP,
  output logic                             RVALID,
  input  logic                             RREADY,
  input  logic [M-1:0]                     INFERED_DIGIT,
  input  logic                             INFER_DONE,
  output logic [IMAGE_SIZE*PIXEL_BITS-1:0] IMAGE,
  output logic                             NEW_IMAGE,
  output logic                             IRQ
);
  localparam int PPW    = AXI_DATA_WIDTH / PIXEL_BITS;
  localparam int NWORDS = IMAGE_SIZE / PPW;
  localparam int WIDX   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [9:0] NWORDS_W = 10'(NWORDS);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic [IMAGE_SIZE*PIXEL_BITS-1:0] image_q;
  logic                             irq_en, done, result_valid;
  logic [M-1:0]                     result_digit;

  // Handshake rule: a beat transfers on an edge where VALID and READY are both high;
  // VALID, once raised, holds its payload until that edge.
  logic                      aw_held, w_held;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]               w_data_q;
  logic [3:0]                w_strb_q;

  assign AWREADY = !ARESETN || (!aw_held && !BVALID);
  assign WREADY  = !ARESETN || (!w_held && !BVALID);
  assign ARREADY = !RVALID;

  logic aw_fire, w_fire, commit;
  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign commit  = (aw_held || aw_fire) && (w_held || w_fire) && !BVALID;

  logic [AXI_ADDR_WIDTH-1:0] cmt_addr;
  logic [31:0]               cmt_data;
  logic [3:0]                cmt_strb;
  assign cmt_addr = aw_held ? aw_addr_q : AWADDR;
  assign cmt_data = w_held ? w_data_q : WDATA;
  assign cmt_strb = w_held ? w_strb_q : WSTRB;

  logic            wr_reg, wr_start, wr_err;
  logic [9:0]      wr_word;
  logic [WIDX-1:0] wr_idx;
  assign wr_reg   = cmt_addr[12];
  assign wr_word  = cmt_addr[11:2];
  assign wr_idx   = wr_word[WIDX-1:0];
  assign wr_start = wr_reg && (wr_word == 10'd0) && cmt_strb[0] && cmt_data[0];

  always_comb begin
    wr_err = 1'b0;
    if (!wr_reg) begin
      wr_err = (wr_word >= NWORDS_W) || (state == BUSY);
    end else begin
      case (wr_word)
        10'd0:        wr_err = wr_start && (state == BUSY);
        10'd1, 10'd2: wr_err = 1'b0;
        default:      wr_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state        <= IDLE;
      image_q      <= '0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result_digit <= '0;
      NEW_IMAGE    <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      BVALID       <= 1'b0;
      BRESP        <= 2'b00;
    end else begin
      NEW_IMAGE <= 1'b0;
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (BVALID && BREADY) begin
        BVALID  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (commit) begin
        BVALID <= 1'b1;
        BRESP  <= wr_err ? 2'b10 : 2'b00;
        if (!wr_reg) begin
          if (!wr_err) begin
            for (int k = 0; k < 4; k++) begin
              if (cmt_strb[k]) image_q[int'(wr_idx)*32 + k*8 +: 8] <= cmt_data[k*8 +: 8];
            end
          end
        end else if (wr_word == 10'd0) begin
          // IRQ_EN follows byte 0 even when a start is rejected as busy.
          if (cmt_strb[0]) irq_en <= cmt_data[1];
          if (wr_start && state == IDLE) begin
            state        <= BUSY;
            NEW_IMAGE    <= 1'b1;
            result_valid <= 1'b0;
            done         <= 1'b0;
          end
        end else if (wr_word == 10'd1) begin
          if (cmt_strb[0] && cmt_data[1]) done <= 1'b0;
        end
      end
      // Placed last so a completion beats a coincident DONE clear.
      if (state == BUSY && INFER_DONE) begin
        state        <= IDLE;
        result_digit <= INFERED_DIGIT;
        result_valid <= 1'b1;
        done         <= 1'b1;
      end
    end
  end

  logic       rd_err;
  logic [9:0] rd_word;
  logic [31:0] rd_data;
  assign rd_word = ARADDR[11:2];
`ifdef SNN_AXIL_READBACK_EN
  logic [WIDX-1:0] rd_idx;
  assign rd_idx = rd_word[WIDX-1:0];
`endif

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (!ARADDR[12]) begin
      if (rd_word >= NWORDS_W) rd_err = 1'b1;
`ifdef SNN_AXIL_READBACK_EN
      else rd_data = image_q[int'(rd_idx)*32 +: 32];
`endif
    end else begin
      case (rd_word)
        10'd0: rd_data[1] = irq_en;
        10'd1: rd_data[1:0] = {done, state == BUSY};
        10'd2: begin
          rd_data[M-1:0] = result_digit;
          rd_data[31]    = result_valid;
        end
        default: rd_err = 1'b1;
      endcase
    end
    if (rd_err) rd_data = '0;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= 2'b00;
    end else if (ARVALID && ARREADY) begin
      RVALID <= 1'b1;
      RDATA  <= rd_data;
      RRESP  <= rd_err ? 2'b10 : 2'b00;
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end

  assign IMAGE = image_q;
  assign IRQ   = done && irq_en;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cmt_addr, ARADDR};
endmodule

// File: tb/tb_axil_image_loader.sv
// Directed bench for axil_image_loader: table of register/pixel transactions plus hand sequences
// for start/inference, reset mid-transaction and the write-response stall.
module tb_axil_image_loader;
  logic          ACLK, ARESETN;
  logic [15:0]   AWADDR, ARADDR;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0]   WDATA, RDATA;
  logic [3:0]    WSTRB;
  logic [1:0]    BRESP, RRESP;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [7:0]    INFERED_DIGIT;
  logic          INFER_DONE, NEW_IMAGE, IRQ;
  logic [2047:0] IMAGE;

  axil_image_loader dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .INFERED_DIGIT(INFERED_DIGIT), .INFER_DONE(INFER_DONE),
    .IMAGE(IMAGE), .NEW_IMAGE(NEW_IMAGE), .IRQ(IRQ)
  );

  // clock / reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;

  always @(negedge ACLK) if (NEW_IMAGE === 1'b1) pulse_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] px(input int i);
    return IMAGE[i*8 +: 8];
  endfunction

  // driver tasks: entered and left just after a rising edge
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_go, w_go, got;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1;
    aw_done = 0; w_done = 0; got = 0; resp = 2'b11;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      @(negedge ACLK);
      aw_go = AWVALID && AWREADY;
      w_go  = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_go) begin aw_done = 1; AWVALID = 1'b0; end
      if (w_go)  begin w_done = 1;  WVALID = 1'b0;  end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    if (!(aw_done && w_done)) check("write_addr_data_timeout", 32'd1, 32'd0);
    BREADY = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge ACLK);
      if (BVALID) begin resp = BRESP; got = 1; end
      @(posedge ACLK); #1;
    end
    BREADY = 1'b0;
    if (!got) check("write_resp_timeout", 32'd1, 32'd0);
  endtask

  task automatic axi_read(input logic [15:0] addr, output logic [1:0] resp, output logic [31:0] data);
    bit go, done_ar, got;
    ARADDR = addr; ARVALID = 1'b1;
    done_ar = 0; got = 0; resp = 2'b11; data = 32'hxxxxxxxx;
    for (int n = 0; n < 20 && !done_ar; n++) begin
      @(negedge ACLK);
      go = ARREADY;
      @(posedge ACLK); #1;
      if (go) done_ar = 1;
    end
    ARVALID = 1'b0;
    if (!done_ar) check("read_addr_timeout", 32'd1, 32'd0);
    RREADY = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge ACLK);
      if (RVALID) begin resp = RRESP; data = RDATA; got = 1; end
      @(posedge ACLK); #1;
    end
    RREADY = 1'b0;
    if (!got) check("read_data_timeout", 32'd1, 32'd0);
  endtask

  task automatic infer(input logic [7:0] digit);
    INFERED_DIGIT = digit; INFER_DONE = 1'b1;
    @(posedge ACLK); #1;
    INFER_DONE = 1'b0;
  endtask

  task automatic wr_chk(input string name, input logic [15:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(addr, data, strb, r);
    check(name, {30'b0, r}, {30'b0, exp_resp});
  endtask

  task automatic rd_chk(input string name, input logic [15:0] addr,
                        input logic [1:0] exp_resp, input logic [31:0] exp_data);
    logic [1:0] r; logic [31:0] d;
    axi_read(addr, r, d);
    check({name, "_resp"}, {30'b0, r}, {30'b0, exp_resp});
    check({name, "_data"}, d, exp_data);
  endtask

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t vecs[15];
  logic [31:0] exp_w1, exp_w63;

  initial begin
    int p0;
    logic [1:0] r;
    logic [31:0] d;
`ifdef SNN_AXIL_READBACK_EN
    exp_w1 = 32'h4433AA11; exp_w63 = 32'h00020004;
`else
    exp_w1 = 32'h0; exp_w63 = 32'h0;
`endif
    vecs[0]  = '{1, 16'h0004, 32'h44332211, 4'hF, 2'b00, 32'h0, "pix_w1_full"};
    vecs[1]  = '{1, 16'h0004, 32'h0000AA00, 4'h2, 2'b00, 32'h0, "pix_w1_strb2"};
    vecs[2]  = '{1, 16'h0100, 32'hDEADBEEF, 4'hF, 2'b10, 32'h0, "pix_out_of_range"};
    vecs[3]  = '{1, 16'h1010, 32'h00000001, 4'hF, 2'b10, 32'h0, "reg_bad_wr"};
    vecs[4]  = '{1, 16'h1000, 32'h00000003, 4'h2, 2'b00, 32'h0, "ctrl_no_strb0"};
    vecs[5]  = '{1, 16'h00FC, 32'h01020304, 4'h5, 2'b00, 32'h0, "pix_last_strb5"};
    vecs[6]  = '{1, 16'h1004, 32'h00000003, 4'hF, 2'b00, 32'h0, "status_w1c_idle"};
    vecs[7]  = '{0, 16'h100C, 32'h0, 4'h0, 2'b10, 32'h0, "reg_bad_rd"};
    vecs[8]  = '{0, 16'h1000, 32'h0, 4'h0, 2'b00, 32'h0, "ctrl_rd"};
    vecs[9]  = '{0, 16'h1004, 32'h0, 4'h0, 2'b00, 32'h0, "status_rd"};
    vecs[10] = '{0, 16'h1008, 32'h0, 4'h0, 2'b00, 32'h0, "result_rd"};
    vecs[11] = '{0, 16'h0004, 32'h0, 4'h0, 2'b00, exp_w1, "pix_w1_rd"};
    vecs[12] = '{0, 16'h0100, 32'h0, 4'h0, 2'b10, 32'h0, "pix_oor_rd"};
    vecs[13] = '{0, 16'h0FFC, 32'h0, 4'h0, 2'b10, 32'h0, "pix_top_rd"};
    vecs[14] = '{0, 16'h00FC, 32'h0, 4'h0, 2'b00, exp_w63, "pix_w63_rd"};

    ARESETN = 1'b0; AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0;
    BREADY = 0; ARADDR = '0; ARVALID = 0; RREADY = 0; INFERED_DIGIT = '0; INFER_DONE = 0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_readys", {29'b0, AWREADY, WREADY, ARREADY}, 32'h7);
    check("rst_valids", {28'b0, BVALID, RVALID, IRQ, NEW_IMAGE}, 32'h0);
    check("rst_resp_rdata", RDATA | {28'b0, BRESP, RRESP}, 32'h0);
    check("rst_image", {31'b0, IMAGE != '0}, 32'h0);
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    check("idle_readys", {29'b0, AWREADY, WREADY, ARREADY}, 32'h7);
    check("idle_valids", {28'b0, BVALID, RVALID, IRQ, NEW_IMAGE}, 32'h0);

    // INFER_DONE while idle must not touch RESULT/STATUS
    infer(8'd9);

    p0 = pulse_cnt;
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) wr_chk(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
      else rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp_resp, vecs[i].exp_rdata);
    end
    check("table_no_pulse", pulse_cnt - p0, 0);
    check("px4_7", {px(7), px(6), px(5), px(4)}, 32'h4433AA11);
    check("px0_3_untouched", IMAGE[31:0], 32'h0);
    check("px252_255", IMAGE[2047:2016], 32'h00020004);

    // start with IRQ_EN, then rejected restarts
    p0 = pulse_cnt;
    wr_chk("start", 16'h1000, 32'h3, 4'hF, 2'b00);
    check("start_pulse", pulse_cnt - p0, 1);
    rd_chk("status_busy", 16'h1004, 2'b00, 32'h1);
    rd_chk("ctrl_irqen", 16'h1000, 2'b00, 32'h2);
    p0 = pulse_cnt;
    wr_chk("double_start", 16'h1000, 32'h1, 4'hF, 2'b10);
    rd_chk("ctrl_irqen_cleared", 16'h1000, 2'b00, 32'h0);
    wr_chk("double_start_irqen", 16'h1000, 32'h3, 4'hF, 2'b10);
    rd_chk("ctrl_irqen_set", 16'h1000, 2'b00, 32'h2);
    check("double_start_no_pulse", pulse_cnt - p0, 0);
    wr_chk("pix_wr_busy", 16'h0000, 32'h55667788, 4'hF, 2'b10);
    check("px0_frozen", IMAGE[31:0], 32'h0);
    check("px4_frozen", {24'b0, px(4)}, 32'h11);

    infer(8'd7);
    rd_chk("result_7", 16'h1008, 2'b00, 32'h80000007);
    rd_chk("status_done", 16'h1004, 2'b00, 32'h2);
    check("irq_set", {31'b0, IRQ}, 32'h1);
    wr_chk("status_clr", 16'h1004, 32'h2, 4'hF, 2'b00);
    check("irq_clr", {31'b0, IRQ}, 32'h0);
    rd_chk("status_cleared", 16'h1004, 2'b00, 32'h0);

    // restart drops RESULT.VALID until the next completion
    wr_chk("restart", 16'h1000, 32'h1, 4'hF, 2'b00);
    axi_read(16'h1008, r, d);
    check("restart_valid_cleared", {31'b0, d[31]}, 32'h0);
    infer(8'd3);
    rd_chk("result_3", 16'h1008, 2'b00, 32'h80000003);

    // reset mid-inference with an AW beat captured
    wr_chk("start_before_rst", 16'h1000, 32'h1, 4'hF, 2'b00);
    AWADDR = 16'h0010; AWVALID = 1'b1;
    @(posedge ACLK); #1;
    ARESETN = 1'b0; AWVALID = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    check("midrst_readys", {29'b0, AWREADY, WREADY, ARREADY}, 32'h7);
    ARESETN = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check("midrst_no_bvalid", {31'b0, BVALID}, 32'h0);
    check("midrst_image", {31'b0, IMAGE != '0}, 32'h0);
    rd_chk("midrst_status", 16'h1004, 2'b00, 32'h0);
    wr_chk("post_rst_pix", 16'h0000, 32'h00000001, 4'h1, 2'b00);
    check("post_rst_px0", IMAGE[31:0], 32'h1);

    // write-response stall with a read running alongside
    AWADDR = 16'h0008; WDATA = 32'hCAFEBABE; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    check("stall_bvalid_rise", {31'b0, BVALID}, 32'h1);
    AWADDR = 16'h000C; AWVALID = 1'b1;
    rd_chk("stall_concurrent_rd", 16'h1004, 2'b00, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      check("stall_hold", {28'b0, BVALID, AWREADY, WREADY, 1'b0}, 32'h8);
      check("stall_bresp", {30'b0, BRESP}, 32'h0);
      @(posedge ACLK); #1;
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check("stall_release", {30'b0, BVALID, AWREADY}, 32'h1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    check("queued_aw_taken", {30'b0, BVALID, AWREADY}, 32'h0);
    WDATA = 32'h0D0C0B0A; WVALID = 1'b1;
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    check("queued_write_commit", {31'b0, BVALID}, 32'h1);
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check("stall_px8_11", IMAGE[95:64], 32'hCAFEBABE);
    check("stall_px12_15", IMAGE[127:96], 32'h0D0C0B0A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
